// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scanner: scan index type,
// active-low cathode patterns {g,f,e,d,c,b,a} and the all-off anode value.
package seg7_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/seven_seg_scanner_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD to active-low seven-segment decoder.
// Values 0-9 give the usual glyphs; anything above 9 shows a dash.
module bcd_to_seg7
    import seg7_pkg::*;
#(
    parameter int DIGIT_WIDTH = 4
) (
    input  logic [DIGIT_WIDTH-1:0] digit,
    output logic [6:0]             segment
);

    // Glyph lookup; non-BCD codes fall through to the dash.
    always_comb begin
        segment = SEG_DASH;
        case (digit)
            DIGIT_WIDTH'(0): segment = SEG_0;
            DIGIT_WIDTH'(1): segment = SEG_1;
            DIGIT_WIDTH'(2): segment = SEG_2;
            DIGIT_WIDTH'(3): segment = SEG_3;
            DIGIT_WIDTH'(4): segment = SEG_4;
            DIGIT_WIDTH'(5): segment = SEG_5;
            DIGIT_WIDTH'(6): segment = SEG_6;
            DIGIT_WIDTH'(7): segment = SEG_7;
            DIGIT_WIDTH'(8): segment = SEG_8;
            DIGIT_WIDTH'(9): segment = SEG_9;
            default:         segment = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed 4-digit common-anode display driver.
// A prescaler sets the slot length, a 2-bit index walks the digits, and the
// digits are snapshotted once per frame (and once after reset) so a frame
// never mixes old and new values. Anodes stay off for the first
// GUARD_CYCLES of each slot to avoid ghosting.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int DIGIT_WIDTH    = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [DIGIT_WIDTH-1:0] digit_ones,
    input  logic [DIGIT_WIDTH-1:0] digit_tens,
    input  logic [DIGIT_WIDTH-1:0] digit_hundreds,
    input  logic [DIGIT_WIDTH-1:0] digit_thousands,
    output logic [3:0]             anode,
    output logic [6:0]             segment,
    output logic                   dp
);

    localparam int PW = $clog2(REFRESH_CYCLES);

    logic [PW-1:0]          prescaler;
    scan_idx_t              index;
    logic [DIGIT_WIDTH-1:0] snapshot [4];
    logic                   load_pending;

    logic                   terminal;
    logic                   load;
    logic                   in_guard;
    logic                   blank;
    logic [DIGIT_WIDTH-1:0] sel_digit;
    logic [6:0]             dec_segment;

    assign terminal  = (prescaler == PW'(REFRESH_CYCLES - 1));
    assign load      = load_pending || (terminal && (index == 2'd3));
    assign in_guard  = (prescaler < PW'(GUARD_CYCLES));
    assign sel_digit = snapshot[index];
    assign dp        = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is blanked when every digit from thousands down to it is zero.
    always_comb begin
        blank = 1'b0;
        case (index)
            2'd3:    blank = (snapshot[3] == '0);
            2'd2:    blank = (snapshot[3] == '0) && (snapshot[2] == '0);
            2'd1:    blank = (snapshot[3] == '0) && (snapshot[2] == '0) &&
                             (snapshot[1] == '0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    bcd_to_seg7 #(
        .DIGIT_WIDTH(DIGIT_WIDTH)
    ) u_dec (
        .digit  (sel_digit),
        .segment(dec_segment)
    );

    // Slot timing: prescaler wraps every slot, index advances on its wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            index     <= 2'd0;
        end else if (terminal) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Frame snapshot: capture all digits after reset and at each 3->0 wrap.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_pending <= 1'b1;
            for (int i = 0; i < 4; i++) snapshot[i] <= '0;
        end else begin
            load_pending <= 1'b0;
            if (load) begin
                snapshot[0] <= digit_ones;
                snapshot[1] <= digit_tens;
                snapshot[2] <= digit_hundreds;
                snapshot[3] <= digit_thousands;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            anode   <= ANODE_OFF;
            segment <= SEG_OFF;
        end else begin
            anode   <= (in_guard || blank) ? ANODE_OFF : ~(4'b0001 << index);
            segment <= dec_segment;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with REFRESH_CYCLES=8, GUARD_CYCLES=2.
// A reference model derived from the edge count since reset release runs
// alongside table-driven and hand-written scenario checks.
module tb_seven_seg_scanner;

    localparam int R = 8;
    localparam int G = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] dig [4];
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;

    int passed = 0;
    int total  = 0;
    int n      = 0;
    logic [3:0] snap [4];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    typedef struct {
        logic [3:0] dg  [4];
        logic [6:0] seg [4];
        logic [3:0] lit;
    } vec_t;
    vec_t tbl [4];

    seven_seg_scanner #(
        .DIGIT_WIDTH   (4),
        .REFRESH_CYCLES(R),
        .GUARD_CYCLES  (G)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .digit_ones     (dig[0]),
        .digit_tens     (dig[1]),
        .digit_hundreds (dig[2]),
        .digit_thousands(dig[3]),
        .anode          (anode),
        .segment        (segment),
        .dp             (dp)
    );

    // clock / reset block
    always #5 clock = ~clock;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Slot is dark if it lies left of the most significant non-zero digit.
    function automatic logic model_blank(input int idx);
        int lead;
        lead = 0;
        for (int i = 0; i < 4; i++) if (snap[i] != 4'd0) lead = i;
`ifdef LEADING_ZERO_BLANK_EN
        return idx > lead;
`else
        return (lead < 0) && (idx > 3);
`endif
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (n=%0d): got %b expected %b", nm, n, act, exp);
    endtask

    // One clock edge: predict outputs from the pre-edge state, then compare.
    task automatic tick();
        int p, idx;
        @(posedge clock);
        n++;
        p   = (n - 1) % R;
        idx = ((n - 1) / R) % 4;
        exp_an  = (p >= G && !model_blank(idx)) ? ~(4'b0001 << idx) : 4'hF;
        exp_seg = glyph(snap[idx]);
        if (n == 1 || (n % (4 * R)) == 0)
            for (int i = 0; i < 4; i++) snap[i] = dig[i];
        @(negedge clock);
        chk("model_anode", {4'd0, anode}, {4'd0, exp_an});
        chk("model_segment", {1'b0, segment}, {1'b0, exp_seg});
    endtask

    task automatic ticks_to(input int target);
        while (n < target) tick();
    endtask

    // Assert reset (checking the async response), load digits, release.
    task automatic do_reset(input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("reset_anode", {4'd0, anode}, 8'h0F);
        chk("reset_segment", {1'b0, segment}, 8'h7F);
        chk("reset_dp", {7'd0, dp}, 8'h01);
        dig[3] = th; dig[2] = hu; dig[1] = te; dig[0] = on;
        n = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dig[i] = 4'd0;

        // Table: digits indexed ones..thousands, expected glyph and lit mask per slot.
        tbl[0].dg = '{4'd1, 4'd8, 4'd8, 4'd1};
        tbl[0].seg = '{7'b1111001, 7'b0000000, 7'b0000000, 7'b1111001};
        tbl[0].lit = 4'b1111;
        tbl[1].dg = '{4'd2, 4'hC, 4'd3, 4'd5};
        tbl[1].seg = '{7'b0100100, 7'b0111111, 7'b0110000, 7'b0010010};
        tbl[1].lit = 4'b1111;
        tbl[2].dg = '{4'd0, 4'd4, 4'd0, 4'd0};
        tbl[2].seg = '{7'b1000000, 7'b0011001, 7'b1000000, 7'b1000000};
        tbl[3].dg = '{4'd0, 4'd0, 4'd0, 4'd0};
        tbl[3].seg = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[2].lit = 4'b0011;
        tbl[3].lit = 4'b0001;
`else
        tbl[2].lit = 4'b1111;
        tbl[3].lit = 4'b1111;
`endif

        for (int v = 0; v < 4; v++) begin
            do_reset(tbl[v].dg[3], tbl[v].dg[2], tbl[v].dg[1], tbl[v].dg[0]);
            for (int s = 0; s < 4; s++) begin
                ticks_to(8 * s + 2);
                chk("tbl_guard_anode", {4'd0, anode}, 8'h0F);
                chk("tbl_guard_segment", {1'b0, segment}, {1'b0, tbl[v].seg[s]});
                ticks_to(8 * s + 6);
                chk("tbl_slot_anode", {4'd0, anode},
                    {4'd0, tbl[v].lit[s] ? ~(4'b0001 << s) : 4'hF});
                chk("tbl_slot_segment", {1'b0, segment}, {1'b0, tbl[v].seg[s]});
            end
        end

        // First lit edge after reset release is GUARD_CYCLES+1.
        do_reset(4'd1, 4'd8, 4'd8, 4'd1);
        ticks_to(G);
        chk("first_dark", {4'd0, anode}, 8'h0F);
        ticks_to(G + 1);
        chk("first_lit", {4'd0, anode}, 8'h0E);
        chk("first_lit_seg", {1'b0, segment}, 8'h79);

        // Mid-frame change of ones waits for the next 3->0 wrap.
        ticks_to(20);
        dig[0] = 4'd0;
        ticks_to(32);
        chk("pre_wrap_thousands", {1'b0, segment}, 8'h79);
        ticks_to(38);
        chk("post_wrap_anode", {4'd0, anode}, 8'h0E);
        chk("post_wrap_ones", {1'b0, segment}, 8'h40);

        // Reset in slot 2, then restart at slot 0 with a fresh snapshot.
        do_reset(4'd1, 4'd8, 4'd8, 4'd1);
        ticks_to(20);
        do_reset(4'd7, 4'd3, 4'd5, 4'd2);
        ticks_to(G + 1);
        chk("restart_anode", {4'd0, anode}, 8'h0E);
        chk("restart_seg", {1'b0, segment}, 8'h24);

        // Randomized digits with random mid-frame changes.
        for (int it = 0; it < 8; it++) begin
            logic [3:0] r [4];
            for (int i = 0; i < 4; i++)
                r[i] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            do_reset(r[3], r[2], r[1], r[0]);
            while (n < 100) begin
                tick();
                if ($urandom_range(0, 9) == 0)
                    dig[$urandom_range(0, 3)] =
                        ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
